// File: rtl/writeback_trap.sv
// Writeback/trap stage: commits register and CSR writes, arbitrates interrupts
// against synchronous exceptions, and squashes wrong-path work after a redirect.
module writeback_trap #(
  parameter int unsigned FLUSH_DEPTH = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] pc_in,
  input  logic [4:0]  rd_address_in,
  input  logic [31:0] rd_data_in,
  input  logic        rd_write_in,
  input  logic [1:0]  csr_op_in,
  input  logic [11:0] csr_address_in,
  input  logic [31:0] csr_old_in,
  input  logic [31:0] csr_operand_in,
  input  logic        exception_in,
  input  logic [3:0]  exception_cause_in,
  input  logic        mret_in,
  input  logic        eip,
  input  logic        tip,
  input  logic        sip,
  output logic        reg_write_enable,
  output logic [4:0]  reg_write_address,
  output logic [31:0] reg_write_data,
  output logic        csr_write_enable,
  output logic [11:0] csr_write_address,
  output logic [31:0] csr_write_data,
  output logic        retired,
  output logic        traped,
  output logic        mret,
  output logic [31:0] ecp,
  output logic [3:0]  trap_cause,
  output logic        interupt,
  output logic        flush,
  output logic        redirect_trap,
  output logic        redirect_mret
);

  localparam logic [1:0] CSR_NONE = 2'b00;
  localparam logic [1:0] CSR_RW   = 2'b01;
  localparam logic [1:0] CSR_RS   = 2'b10;
  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_DEPTH);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  logic [3:0]  flush_count;

  logic        irq_pending;
  logic [3:0]  irq_cause;
  logic [31:0] csr_next;
  logic        csr_write_next;

  // Machine external beats software beats timer.
  always_comb begin
    irq_pending = eip | tip | sip;
    irq_cause   = 4'd7;
    if (eip)
      irq_cause = 4'd11;
    else if (sip)
      irq_cause = 4'd3;
  end

  // Set/clear with a zero operand must leave the CSR untouched (no side effects).
  always_comb begin
    csr_next       = csr_operand_in;
    csr_write_next = 1'b0;
    case (csr_op_in)
      CSR_RW: begin
        csr_next       = csr_operand_in;
        csr_write_next = 1'b1;
      end
      CSR_RS: begin
        csr_next       = csr_old_in | csr_operand_in;
        csr_write_next = (csr_operand_in != 32'd0);
      end
      default: begin
        csr_next       = csr_old_in & ~csr_operand_in;
        csr_write_next = (csr_op_in != CSR_NONE) && (csr_operand_in != 32'd0);
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= RUN;
      flush_count       <= 4'd0;
      reg_write_enable  <= 1'b0;
      reg_write_address <= 5'd0;
      reg_write_data    <= 32'd0;
      csr_write_enable  <= 1'b0;
      csr_write_address <= 12'd0;
      csr_write_data    <= 32'd0;
      retired           <= 1'b0;
      traped            <= 1'b0;
      mret              <= 1'b0;
      ecp               <= 32'd0;
      trap_cause        <= 4'd0;
      interupt          <= 1'b0;
      flush             <= 1'b0;
      redirect_trap     <= 1'b0;
      redirect_mret     <= 1'b0;
    end else begin
      reg_write_enable <= 1'b0;
      csr_write_enable <= 1'b0;
      retired          <= 1'b0;
      traped           <= 1'b0;
      mret             <= 1'b0;
      interupt         <= 1'b0;
      flush            <= 1'b0;
      redirect_trap    <= 1'b0;
      redirect_mret    <= 1'b0;
      case (state)
        RUN: begin
          if (valid_in) begin
            if (irq_pending || exception_in) begin
              traped        <= 1'b1;
              interupt      <= irq_pending;
              ecp           <= pc_in;
              trap_cause    <= irq_pending ? irq_cause : exception_cause_in;
              flush         <= 1'b1;
              redirect_trap <= 1'b1;
              state         <= FLUSH;
              flush_count   <= FLUSH_LOAD;
            end else if (mret_in) begin
              mret          <= 1'b1;
              retired       <= 1'b1;
              flush         <= 1'b1;
              redirect_mret <= 1'b1;
              state         <= FLUSH;
              flush_count   <= FLUSH_LOAD;
            end else begin
              retired           <= 1'b1;
              reg_write_enable  <= rd_write_in && (rd_address_in != 5'd0);
              reg_write_address <= rd_address_in;
              reg_write_data    <= (csr_op_in != CSR_NONE) ? csr_old_in : rd_data_in;
              csr_write_enable  <= csr_write_next;
              csr_write_address <= csr_address_in;
              csr_write_data    <= csr_next;
            end
          end
        end
        FLUSH: begin
          flush_count <= flush_count - 4'd1;
          if (flush_count <= 4'd1)
            state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_trap.sv
// Directed self-checking bench for writeback_trap with hand-computed expectations.
module tb_writeback_trap;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] pc_in;
  logic [4:0]  rd_address_in;
  logic [31:0] rd_data_in;
  logic        rd_write_in;
  logic [1:0]  csr_op_in;
  logic [11:0] csr_address_in;
  logic [31:0] csr_old_in;
  logic [31:0] csr_operand_in;
  logic        exception_in;
  logic [3:0]  exception_cause_in;
  logic        mret_in;
  logic        eip, tip, sip;
  logic        reg_write_enable;
  logic [4:0]  reg_write_address;
  logic [31:0] reg_write_data;
  logic        csr_write_enable;
  logic [11:0] csr_write_address;
  logic [31:0] csr_write_data;
  logic        retired, traped, mret;
  logic [31:0] ecp;
  logic [3:0]  trap_cause;
  logic        interupt, flush, redirect_trap, redirect_mret;

  int checkCount = 0;
  int errorCount = 0;

  writeback_trap #(.FLUSH_DEPTH(3)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .pc_in(pc_in),
    .rd_address_in(rd_address_in), .rd_data_in(rd_data_in), .rd_write_in(rd_write_in),
    .csr_op_in(csr_op_in), .csr_address_in(csr_address_in), .csr_old_in(csr_old_in),
    .csr_operand_in(csr_operand_in), .exception_in(exception_in),
    .exception_cause_in(exception_cause_in), .mret_in(mret_in),
    .eip(eip), .tip(tip), .sip(sip),
    .reg_write_enable(reg_write_enable), .reg_write_address(reg_write_address),
    .reg_write_data(reg_write_data), .csr_write_enable(csr_write_enable),
    .csr_write_address(csr_write_address), .csr_write_data(csr_write_data),
    .retired(retired), .traped(traped), .mret(mret), .ecp(ecp),
    .trap_cause(trap_cause), .interupt(interupt), .flush(flush),
    .redirect_trap(redirect_trap), .redirect_mret(redirect_mret)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic clearInputs();
    valid_in = 0; pc_in = 0; rd_address_in = 0; rd_data_in = 0; rd_write_in = 0;
    csr_op_in = 0; csr_address_in = 0; csr_old_in = 0; csr_operand_in = 0;
    exception_in = 0; exception_cause_in = 0; mret_in = 0; eip = 0; tip = 0; sip = 0;
  endtask

  // Sample the current inputs on the next rising edge and settle past it.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  task automatic commitVector(input logic [31:0] pc, input logic [4:0] rd, input logic [31:0] data);
    clearInputs();
    valid_in = 1; pc_in = pc; rd_address_in = rd; rd_data_in = data; rd_write_in = 1;
    applyStimulus();
  endtask

  task automatic csrVector(input logic [1:0] op, input logic [31:0] old_value, input logic [31:0] operand);
    clearInputs();
    valid_in = 1; pc_in = 32'h180; rd_address_in = 5'd6; rd_write_in = 1; rd_data_in = 32'hDEAD;
    csr_op_in = op; csr_address_in = 12'h340; csr_old_in = old_value; csr_operand_in = operand;
    applyStimulus();
  endtask

  initial begin
    clearInputs();
    reset = 1;
    #12;
    checkOutput("reset_retired", 32'(retired), 0);
    checkOutput("reset_traped", 32'(traped), 0);
    checkOutput("reset_ecp", ecp, 0);
    checkOutput("reset_flush", 32'(flush), 0);
    checkOutput("reset_rwe", 32'(reg_write_enable), 0);
    @(negedge clk);
    reset = 0;

    commitVector(32'h100, 5'd5, 32'h1234);
    checkOutput("commit_rwe", 32'(reg_write_enable), 1);
    checkOutput("commit_addr", 32'(reg_write_address), 5);
    checkOutput("commit_data", reg_write_data, 32'h1234);
    checkOutput("commit_retired", 32'(retired), 1);
    checkOutput("commit_traped", 32'(traped), 0);
    checkOutput("commit_csr_we", 32'(csr_write_enable), 0);

    csrVector(2'b10, 32'h0F, 32'hF0);
    checkOutput("rs_csr_we", 32'(csr_write_enable), 1);
    checkOutput("rs_csr_addr", 32'(csr_write_address), 32'h340);
    checkOutput("rs_csr_data", csr_write_data, 32'hFF);
    checkOutput("rs_rwe", 32'(reg_write_enable), 1);
    checkOutput("rs_rd_data", reg_write_data, 32'h0F);

    csrVector(2'b10, 32'h0F, 32'h0);
    checkOutput("rs0_csr_we", 32'(csr_write_enable), 0);
    checkOutput("rs0_rwe", 32'(reg_write_enable), 1);
    checkOutput("rs0_rd_data", reg_write_data, 32'h0F);

    csrVector(2'b11, 32'hFF, 32'h0F);
    checkOutput("rc_csr_we", 32'(csr_write_enable), 1);
    checkOutput("rc_csr_data", csr_write_data, 32'hF0);

    csrVector(2'b01, 32'h55, 32'h0);
    checkOutput("rw_csr_we", 32'(csr_write_enable), 1);
    checkOutput("rw_csr_data", csr_write_data, 32'h0);
    checkOutput("rw_rd_data", reg_write_data, 32'h55);

    commitVector(32'h104, 5'd0, 32'h77);
    checkOutput("x0_rwe", 32'(reg_write_enable), 0);
    checkOutput("x0_retired", 32'(retired), 1);

    clearInputs();
    eip = 1;
    applyStimulus();
    checkOutput("bubble_traped", 32'(traped), 0);
    checkOutput("bubble_retired", 32'(retired), 0);

    clearInputs();
    valid_in = 1; pc_in = 32'h200; tip = 1; sip = 1; exception_in = 1; exception_cause_in = 4'd2;
    rd_write_in = 1; rd_address_in = 5'd3;
    applyStimulus();
    checkOutput("irq_traped", 32'(traped), 1);
    checkOutput("irq_interupt", 32'(interupt), 1);
    checkOutput("irq_cause", 32'(trap_cause), 3);
    checkOutput("irq_ecp", ecp, 32'h200);
    checkOutput("irq_retired", 32'(retired), 0);
    checkOutput("irq_rwe", 32'(reg_write_enable), 0);
    checkOutput("irq_flush", 32'(flush), 1);
    checkOutput("irq_redirect", 32'(redirect_trap), 1);

    // Pending interrupts must be ignored throughout the flush window.
    for (int i = 0; i < 3; i++) begin
      clearInputs();
      valid_in = 1; pc_in = 32'h204; rd_address_in = 5'd7; rd_write_in = 1; eip = 1;
      applyStimulus();
      checkOutput($sformatf("irqflush%0d_traped", i), 32'(traped), 0);
      checkOutput($sformatf("irqflush%0d_retired", i), 32'(retired), 0);
      checkOutput($sformatf("irqflush%0d_rwe", i), 32'(reg_write_enable), 0);
    end
    commitVector(32'h208, 5'd8, 32'hABCD);
    checkOutput("postirq_retired", 32'(retired), 1);
    checkOutput("postirq_data", reg_write_data, 32'hABCD);

    clearInputs();
    valid_in = 1; pc_in = 32'h240; exception_in = 1; exception_cause_in = 4'd5; rd_write_in = 1; rd_address_in = 5'd9;
    applyStimulus();
    checkOutput("exc_traped", 32'(traped), 1);
    checkOutput("exc_interupt", 32'(interupt), 0);
    checkOutput("exc_cause", 32'(trap_cause), 5);
    checkOutput("exc_ecp", ecp, 32'h240);
    checkOutput("exc_rwe", 32'(reg_write_enable), 0);
    clearInputs();
    repeat (3) applyStimulus();

    clearInputs();
    valid_in = 1; pc_in = 32'h250; tip = 1;
    applyStimulus();
    checkOutput("mti_cause", 32'(trap_cause), 7);
    clearInputs();
    repeat (3) applyStimulus();

    clearInputs();
    valid_in = 1; pc_in = 32'h300; mret_in = 1; rd_write_in = 1; rd_address_in = 5'd4;
    applyStimulus();
    checkOutput("mret_mret", 32'(mret), 1);
    checkOutput("mret_redirect", 32'(redirect_mret), 1);
    checkOutput("mret_retired", 32'(retired), 1);
    checkOutput("mret_flush", 32'(flush), 1);
    checkOutput("mret_traped", 32'(traped), 0);
    checkOutput("mret_rwe", 32'(reg_write_enable), 0);
    for (int i = 0; i < 3; i++) begin
      commitVector(32'h304 + 32'(4 * i), 5'd10, 32'h10 + 32'(i));
      checkOutput($sformatf("mflush%0d_retired", i), 32'(retired), 0);
      checkOutput($sformatf("mflush%0d_mret", i), 32'(mret), 0);
      checkOutput($sformatf("mflush%0d_redirect", i), 32'(redirect_mret), 0);
      checkOutput($sformatf("mflush%0d_flush", i), 32'(flush), 0);
    end
    commitVector(32'h310, 5'd11, 32'h99);
    checkOutput("after_mret_retired", 32'(retired), 1);
    checkOutput("after_mret_rwe", 32'(reg_write_enable), 1);
    checkOutput("after_mret_data", reg_write_data, 32'h99);

    clearInputs();
    valid_in = 1; pc_in = 32'h400; eip = 1; sip = 1;
    applyStimulus();
    checkOutput("mei_cause", 32'(trap_cause), 11);
    checkOutput("mei_traped", 32'(traped), 1);
    clearInputs();
    #2;
    reset = 1;
    #1;
    checkOutput("async_traped", 32'(traped), 0);
    checkOutput("async_flush", 32'(flush), 0);
    checkOutput("async_redirect", 32'(redirect_trap), 0);
    checkOutput("async_ecp", ecp, 0);
    @(negedge clk);
    reset = 0;
    commitVector(32'h500, 5'd12, 32'h4242);
    checkOutput("postreset_retired", 32'(retired), 1);
    checkOutput("postreset_rwe", 32'(reg_write_enable), 1);
    checkOutput("postreset_data", reg_write_data, 32'h4242);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
